// File: rtl/ccff_chain_loader_if.sv
// Bundle of host bitstream, chain serial and readback signals for the chain loader.
// The loader side uses the slave modport; the host/chain side uses master.
interface ccff_chain_loader_if #(
  parameter int CHAIN_LEN = 1024,
  parameter int DATA_W    = 32
);
  localparam int CNT_W = $clog2(CHAIN_LEN + 1);

  logic              start;
  logic [DATA_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic              ccff_head;
  logic              shift_en;
  logic              ccff_tail;
  logic [DATA_W-1:0] rb_data;
  logic              rb_valid;
  logic              rb_ready;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  bit_cnt;

  modport master (
    output start, cfg_data, cfg_valid, ccff_tail, rb_ready,
    input  cfg_ready, ccff_head, shift_en, rb_data, rb_valid, busy, done, bit_cnt
  );

  modport slave (
    input  start, cfg_data, cfg_valid, ccff_tail, rb_ready,
    output cfg_ready, ccff_head, shift_en, rb_data, rb_valid, busy, done, bit_cnt
  );
endinterface

// File: rtl/ccff_chain_loader.sv
// Serializes host words into a configuration chain head while collecting the bits
// leaving the chain tail into readback words.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 1024,
  parameter int DATA_W    = 32
) (
  input logic prog_clk,
  input logic prog_reset,
  ccff_chain_loader_if.slave bus
);
  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int BC_W  = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FLUSH, S_DONE} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_buf;
  logic [BC_W-1:0]   r_bufCnt;
  logic [CNT_W-1:0]  r_loaded;
  logic [CNT_W-1:0]  r_bitCnt;
  logic [DATA_W-1:0] r_col;
  logic [BC_W-1:0]   r_colCnt;
  logic [DATA_W-1:0] r_rbData;
  logic              r_rbValid;

  logic              w_rbFree;
  logic              w_colFull;
  logic              w_blocked;
  logic              w_shift;
  logic              w_lastBit;
  logic              w_cfgReady;
  logic              w_cfgFire;
  logic [CNT_W-1:0]  w_remain;
  logic [BC_W-1:0]   w_loadCnt;
  logic [DATA_W-1:0] w_colShift;

  assign w_rbFree   = !r_rbValid || bus.rb_ready;
  assign w_colFull  = (r_colCnt == BC_W'(DATA_W));
  assign w_blocked  = r_rbValid && !bus.rb_ready && w_colFull;
  assign w_shift    = (r_state == S_SHIFT) && (r_bufCnt != '0) && !w_blocked;
  assign w_lastBit  = w_shift && (r_bitCnt == CNT_W'(CHAIN_LEN - 1));
  // A new word is only taken while chain bits remain unloaded.
  assign w_cfgReady = (r_state == S_SHIFT) && (r_loaded != CNT_W'(CHAIN_LEN)) &&
                      ((r_bufCnt == '0) || ((r_bufCnt == BC_W'(1)) && w_shift));
  assign w_cfgFire  = w_cfgReady && bus.cfg_valid;
  assign w_remain   = CNT_W'(CHAIN_LEN) - r_loaded;
  assign w_colShift = {r_col[DATA_W-2:0], bus.ccff_tail};

  always_comb begin
    w_loadCnt = BC_W'(DATA_W);
    if (int'(w_remain) < DATA_W) w_loadCnt = BC_W'(int'(w_remain));
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      r_state   <= S_IDLE;
      r_buf     <= '0;
      r_bufCnt  <= '0;
      r_loaded  <= '0;
      r_bitCnt  <= '0;
      r_col     <= '0;
      r_colCnt  <= '0;
      r_rbData  <= '0;
      r_rbValid <= 1'b0;
    end else begin
      if (r_rbValid && bus.rb_ready) r_rbValid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state  <= S_SHIFT;
            r_bitCnt <= '0;
            r_loaded <= '0;
          end
        end
        S_SHIFT: begin
          if (w_shift) begin
            r_bitCnt <= r_bitCnt + CNT_W'(1);
            if (w_lastBit) r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if ((r_colCnt == '0) && w_rbFree) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_cfgFire) begin
        r_buf    <= bus.cfg_data;
        r_bufCnt <= w_loadCnt;
        r_loaded <= r_loaded + CNT_W'(w_loadCnt);
      end else if (w_shift) begin
        if (w_lastBit) begin
          r_buf    <= '0;
          r_bufCnt <= '0;
        end else begin
          r_buf    <= r_buf << 1;
          r_bufCnt <= r_bufCnt - BC_W'(1);
        end
      end

      // A full collector parks here until the readback slot frees up.
      if (w_shift) begin
        if (w_colFull) begin
          r_rbData  <= r_col;
          r_rbValid <= 1'b1;
          r_col     <= {{(DATA_W-1){1'b0}}, bus.ccff_tail};
          r_colCnt  <= BC_W'(1);
        end else if (r_colCnt == BC_W'(DATA_W - 1)) begin
          if (w_rbFree) begin
            r_rbData  <= w_colShift;
            r_rbValid <= 1'b1;
            r_col     <= '0;
            r_colCnt  <= '0;
          end else begin
            r_col    <= w_colShift;
            r_colCnt <= BC_W'(DATA_W);
          end
        end else begin
          r_col    <= w_colShift;
          r_colCnt <= r_colCnt + BC_W'(1);
        end
      end else if (w_colFull && w_rbFree) begin
        r_rbData  <= r_col;
        r_rbValid <= 1'b1;
        r_col     <= '0;
        r_colCnt  <= '0;
      end else if ((r_state == S_FLUSH) && (r_colCnt != '0) && w_rbFree) begin
        r_rbData  <= r_col << (DATA_W - int'(r_colCnt));
        r_rbValid <= 1'b1;
        r_col     <= '0;
        r_colCnt  <= '0;
      end
    end
  end

  assign bus.cfg_ready = w_cfgReady;
  assign bus.ccff_head = r_buf[DATA_W-1];
  assign bus.shift_en  = w_shift;
  assign bus.rb_data   = r_rbData;
  assign bus.rb_valid  = r_rbValid;
  assign bus.busy      = (r_state == S_SHIFT) || (r_state == S_FLUSH);
  assign bus.done      = (r_state == S_DONE);
  assign bus.bit_cnt   = r_bitCnt;
endmodule

// File: tb/tb_ccff_chain_loader.sv
// Self-checking bench: a 70-bit chain driven from a vector table and a 64-bit chain
// for the exact-multiple case, with a readback scoreboard per chain.
module tb_ccff_chain_loader;
  logic prog_clk = 1'b0;
  logic prog_reset;
  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader_if #(.CHAIN_LEN(70), .DATA_W(32)) busA ();
  ccff_chain_loader_if #(.CHAIN_LEN(64), .DATA_W(32)) busB ();

  ccff_chain_loader #(.CHAIN_LEN(70), .DATA_W(32)) dutA (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .bus(busA));
  ccff_chain_loader #(.CHAIN_LEN(64), .DATA_W(32)) dutB (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .bus(busB));

  // Chain models: shift toward the MSB, tail is the MSB.
  logic [69:0] chainA, preA;
  logic [63:0] chainB, preB;
  logic        loadA, loadB;
  always @(posedge prog_clk) begin
    if (loadA) chainA <= preA;
    else if (busA.shift_en) chainA <= {chainA[68:0], busA.ccff_head};
    if (loadB) chainB <= preB;
    else if (busB.shift_en) chainB <= {chainB[62:0], busB.ccff_head};
  end
  assign busA.ccff_tail = chainA[69];
  assign busB.ccff_tail = chainB[63];

  int checks = 0;
  int failures = 0;
  logic [31:0] qA[$];
  logic [31:0] qB[$];

  typedef struct {
    string            name;
    logic [69:0]      pre;
    logic [2:0][31:0] w;
    int               gap;
    int               rbHold;
    int               abortAt;
    bit               extraStarts;
    int               expFirst;
    int               expSpan;
    int               expFrozen;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int cyc, firstShift, lastShift, shifts, dones, pops, gapLeft, holdLeft, widx, doneCyc, maxCnt;
    bit cfgFire, readyObs, seenRb, finished, aborted;
    logic [31:0] expRb;
    cyc = 0; firstShift = -1; lastShift = -1; shifts = 0; dones = 0; pops = 0;
    gapLeft = 0; holdLeft = 0; widx = 0; doneCyc = 0; maxCnt = 0;
    seenRb = 0; finished = 0; aborted = 0;
    @(posedge prog_clk); #1;
    preA = v.pre; loadA = 1'b1;
    @(posedge prog_clk); #1;
    loadA = 1'b0;
    qA.delete();
    qA.push_back(v.pre[69:38]);
    qA.push_back(v.pre[37:6]);
    qA.push_back({v.pre[5:0], 26'b0});
    busA.cfg_data = v.w[0]; busA.cfg_valid = 1'b1;
    busA.rb_ready = (v.rbHold == 0); busA.start = 1'b1;
    while (!finished && cyc < 400) begin
      @(negedge prog_clk);
      cfgFire  = busA.cfg_valid && busA.cfg_ready;
      readyObs = busA.cfg_ready;
      if (int'(busA.bit_cnt) > maxCnt) maxCnt = int'(busA.bit_cnt);
      if (busA.shift_en) begin
        if (firstShift < 0) firstShift = cyc;
        lastShift = cyc;
        shifts++;
      end
      if (busA.rb_valid && busA.rb_ready) begin
        expRb = (qA.size() != 0) ? qA.pop_front() : 32'hxxxx_xxxx;
        checkOutput($sformatf("%s rb_data[%0d]", v.name, pops), busA.rb_data, expRb);
        pops++;
      end
      if (busA.rb_valid && !seenRb) begin
        seenRb = 1; holdLeft = v.rbHold;
      end
      if (v.expFrozen != 0 && seenRb && holdLeft == 1) begin
        checkOutput({v.name, " frozen_bit_cnt"}, busA.bit_cnt, v.expFrozen);
        checkOutput({v.name, " frozen_shift_en"}, busA.shift_en, 0);
        checkOutput({v.name, " held_rb_data"}, busA.rb_data, qA[0]);
      end
      if (busA.done) begin
        dones++; doneCyc = cyc;
        if (v.extraStarts) busA.start = 1'b1;
      end
      if (v.abortAt != 0 && int'(busA.bit_cnt) == v.abortAt) begin
        prog_reset = 1'b1;
        @(negedge prog_clk);
        checkOutput({v.name, " reset_outputs"},
          {busA.cfg_ready, busA.ccff_head, busA.shift_en, busA.rb_valid, busA.rb_data,
           busA.busy, busA.done, busA.bit_cnt}, 0);
        prog_reset = 1'b0;
        busA.start = 1'b0; busA.cfg_valid = 1'b0; busA.rb_ready = 1'b1;
        qA.delete();
        aborted = 1; finished = 1;
      end else begin
        if (dones > 0 && cyc >= doneCyc + 3) finished = 1;
        @(posedge prog_clk); #1;
        busA.start = v.extraStarts && (cyc == 20);
        if (cfgFire) begin
          widx++; gapLeft = v.gap;
        end else if (!busA.cfg_valid && readyObs && gapLeft > 0) begin
          gapLeft--;
        end
        busA.cfg_valid = (widx < 3) && (gapLeft == 0);
        if (widx < 3) busA.cfg_data = v.w[widx];
        if (seenRb && holdLeft > 0) holdLeft--;
        busA.rb_ready = (v.rbHold == 0) || (seenRb && holdLeft == 0);
        cyc++;
      end
    end
    checkOutput({v.name, " finished"}, finished, 1);
    if (aborted) begin
      checkOutput({v.name, " abort_no_done"}, dones, 0);
    end else begin
      checkOutput({v.name, " first_shift"}, firstShift, v.expFirst);
      checkOutput({v.name, " shift_count"}, shifts, 70);
      if (v.expSpan != 0) checkOutput({v.name, " shift_span"}, lastShift - firstShift, v.expSpan);
      checkOutput({v.name, " done_pulses"}, dones, 1);
      checkOutput({v.name, " rb_words"}, pops, 3);
      checkOutput({v.name, " chain"}, chainA, {v.w[0], v.w[1], v.w[2][31:26]});
      checkOutput({v.name, " bit_cnt_end"}, busA.bit_cnt, 70);
      checkOutput({v.name, " bit_cnt_max"}, maxCnt, 70);
      checkOutput({v.name, " busy_end"}, busA.busy, 0);
    end
    busA.cfg_valid = 1'b0; busA.start = 1'b0; busA.rb_ready = 1'b1;
  endtask

  // Exact multiple: no padded word, done the cycle after the last readback accept.
  task automatic runExactB();
    int cyc, shifts, pops, dones, doneCyc, lastAcc, widx;
    bit cfgFire, coincide, finished;
    logic [31:0] w[2];
    logic [31:0] expRb;
    cyc = 0; shifts = 0; pops = 0; dones = 0; doneCyc = -1; lastAcc = -1; widx = 0;
    coincide = 0; finished = 0;
    w[0] = 32'hA5A5_0F0F; w[1] = 32'h3C3C_9696;
    @(posedge prog_clk); #1;
    preB = 64'h0123_4567_89AB_CDEF; loadB = 1'b1;
    @(posedge prog_clk); #1;
    loadB = 1'b0;
    qB.delete();
    qB.push_back(preB[63:32]);
    qB.push_back(preB[31:0]);
    busB.cfg_data = w[0]; busB.cfg_valid = 1'b1; busB.rb_ready = 1'b1; busB.start = 1'b1;
    while (!finished && cyc < 300) begin
      @(negedge prog_clk);
      cfgFire = busB.cfg_valid && busB.cfg_ready;
      if (cfgFire && widx == 1 && busB.shift_en) coincide = 1;
      if (busB.shift_en) shifts++;
      if (busB.rb_valid && busB.rb_ready) begin
        expRb = (qB.size() != 0) ? qB.pop_front() : 32'hxxxx_xxxx;
        checkOutput($sformatf("exact rb_data[%0d]", pops), busB.rb_data, expRb);
        pops++; lastAcc = cyc;
      end
      if (busB.done) begin
        dones++; doneCyc = cyc;
      end
      if (dones > 0 && cyc >= doneCyc + 3) finished = 1;
      @(posedge prog_clk); #1;
      busB.start = 1'b0;
      if (cfgFire) widx++;
      busB.cfg_valid = (widx < 2);
      if (widx < 2) busB.cfg_data = w[widx];
      cyc++;
    end
    checkOutput("exact finished", finished, 1);
    checkOutput("exact shift_count", shifts, 64);
    checkOutput("exact rb_words", pops, 2);
    checkOutput("exact done_after_accept", doneCyc, lastAcc + 1);
    checkOutput("exact done_pulses", dones, 1);
    checkOutput("exact cfg_with_last_bit", coincide, 1);
    checkOutput("exact chain", chainB, {w[0], w[1]});
    checkOutput("exact bit_cnt_end", busB.bit_cnt, 64);
    busB.cfg_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    prog_reset = 1'b1; loadA = 1'b0; loadB = 1'b0;
    busA.start = 1'b0; busA.cfg_valid = 1'b0; busA.cfg_data = '0; busA.rb_ready = 1'b1;
    busB.start = 1'b0; busB.cfg_valid = 1'b0; busB.cfg_data = '0; busB.rb_ready = 1'b1;
    repeat (3) @(posedge prog_clk);
    @(negedge prog_clk);
    checkOutput("reset_A", {busA.cfg_ready, busA.ccff_head, busA.shift_en, busA.rb_valid,
      busA.rb_data, busA.busy, busA.done, busA.bit_cnt}, 0);
    checkOutput("reset_B", {busB.cfg_ready, busB.ccff_head, busB.shift_en, busB.rb_valid,
      busB.rb_data, busB.busy, busB.done, busB.bit_cnt}, 0);
    prog_reset = 1'b0;
    busA.cfg_valid = 1'b1; busA.cfg_data = 32'hFFFF_FFFF;
    @(negedge prog_clk);
    checkOutput("idle_cfg_ready", busA.cfg_ready, 0);
    @(negedge prog_clk);
    checkOutput("idle_no_load", busA.ccff_head, 0);
    busA.cfg_valid = 1'b0;

    vecs[0] = '{"nominal", 70'h2A_5555_5555_AAAA_AAAA, {32'hFC00_0000, 32'h1234_5678, 32'hDEAD_BEEF},
                0, 0, 0, 1'b0, 2, 69, 0};
    vecs[1] = '{"backpressure", 70'h2A_5555_5555_AAAA_AAAA, {32'hFC00_0000, 32'h1234_5678, 32'hDEAD_BEEF},
                0, 40, 0, 1'b0, 2, 0, 64};
    vecs[2] = '{"starvation", 70'h2A_5555_5555_AAAA_AAAA, {32'hFC00_0000, 32'h1234_5678, 32'hDEAD_BEEF},
                5, 0, 0, 1'b0, 2, 79, 0};
    vecs[3] = '{"abort", 70'h2A_5555_5555_AAAA_AAAA, {32'hFC00_0000, 32'h1234_5678, 32'hDEAD_BEEF},
                0, 0, 40, 1'b0, 2, 0, 0};
    vecs[4] = '{"recovery", 70'h3F_0F0F_0F0F_1234_5678, {32'h55AA_55AA, 32'h0BAD_C0DE, 32'hCAFE_F00D},
                0, 0, 0, 1'b0, 2, 69, 0};
    vecs[5] = '{"extra_start", 70'h15_C3C3_3C3C_F0F0_0F0F, {32'h8400_0000, 32'h7654_3210, 32'h0F1E_2D3C},
                0, 0, 0, 1'b1, 2, 69, 0};

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);
    runExactB();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
